mem_load_align: RTL and testbench

Parametrised load alignment and extension unit between the CPU memory stage and the data bus. Accepts one load request at a time (byte, halfword or word at any byte address), issues word-aligned bus reads, extracts and zero- or sign-extends the addressed bytes, and returns the result over a valid/ready handshake. Word-crossing accesses are either split into two bus reads or rejected with an error, depending on build configuration.

---
 rtl/mem_load_align_if.sv | 31 +++
 rtl/mem_load_align.sv | 158 +++++++++++++++
 tb/tb_mem_load_align.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_load_align_if.sv
// Load-unit bundle: CPU request, word-aligned bus read channel and extended result.
// reqMode encoding: 2'b00 byte, 2'b01 halfword, 2'b10 word.
interface mem_load_align_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              reqValid;
  logic              reqReady;
  logic [ADDR_W-1:0] reqAddr;
  logic [1:0]        reqMode;
  logic              reqSigned;
  logic              busValid;
  logic              busReady;
  logic [ADDR_W-1:0] busAddr;
  logic              busRspValid;
  logic [DATA_W-1:0] busRdata;
  logic              rspValid;
  logic              rspReady;
  logic [DATA_W-1:0] rspData;
  logic              rspErr;

  modport slave (
    input  reqValid, reqAddr, reqMode, reqSigned, busReady, busRspValid, busRdata, rspReady,
    output reqReady, busValid, busAddr, rspValid, rspData, rspErr
  );

  modport master (
    output reqValid, reqAddr, reqMode, reqSigned, busReady, busRspValid, busRdata, rspReady,
    input  reqReady, busValid, busAddr, rspValid, rspData, rspErr
  );
endinterface

// File: rtl/mem_load_align.sv
// Load align/extend unit: 3 cycles on a zero-wait bus (5 when split), one request in flight,
// stalls on busReady/rspReady. MEM_SPLIT_EN splits word-crossing loads, else they return rspErr.
module mem_load_align #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rstN,
  mem_load_align_if.slave bif
);
  localparam int         BYTES   = DATA_W / 8;
  localparam int         OFF_W   = $clog2(BYTES);
  localparam logic [7:0] BYTES_L = 8'(BYTES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_WT0  = 3'd2;
`ifdef MEM_SPLIT_EN
  localparam logic [2:0] S_RD1  = 3'd3;
  localparam logic [2:0] S_WT1  = 3'd4;
`endif
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]        r_state;
  logic              r_live;
  logic [ADDR_W-1:0] r_waddr;
  logic [OFF_W-1:0]  r_off;
  logic [1:0]        r_mode;
  logic              r_signed;
  logic [DATA_W-1:0] r_data;
  logic              r_err;
`ifdef MEM_SPLIT_EN
  logic              r_cross;
  logic [DATA_W-1:0] r_word0;
`endif

  logic [7:0]          w_req_size;
  logic [7:0]          w_req_end;
  logic                w_req_cross;
  logic [2*DATA_W-1:0] w_pair;
  logic [DATA_W-1:0]   w_shift;
  logic [DATA_W-1:0]   w_ext;
  logic                w_sign;
  int                  w_nbits;

  always_comb begin
    case (bif.reqMode)
      2'b00:   w_req_size = 8'd1;
      2'b01:   w_req_size = 8'd2;
      default: w_req_size = 8'd4;
    endcase
    w_req_end   = 8'(bif.reqAddr[OFF_W-1:0]) + w_req_size;
    w_req_cross = (w_req_end > BYTES_L);
  end

  // Second word sits above the first so one right shift lines up any crossing field.
  always_comb begin
`ifdef MEM_SPLIT_EN
    w_pair = (r_state == S_WT1) ? {bif.busRdata, r_word0} : {{DATA_W{1'b0}}, bif.busRdata};
`else
    w_pair = {{DATA_W{1'b0}}, bif.busRdata};
`endif
    w_shift = DATA_W'(w_pair >> {r_off, 3'b000});
    case (r_mode)
      2'b00:   begin w_nbits = 8;  w_sign = w_shift[7];  end
      2'b01:   begin w_nbits = 16; w_sign = w_shift[15]; end
      default: begin w_nbits = 32; w_sign = w_shift[31]; end
    endcase
    w_ext = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_ext[i] = (i < w_nbits) ? w_shift[i] : (r_signed & w_sign);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= S_IDLE;
      r_live   <= 1'b0;
      r_waddr  <= '0;
      r_off    <= '0;
      r_mode   <= 2'b00;
      r_signed <= 1'b0;
      r_data   <= '0;
      r_err    <= 1'b0;
`ifdef MEM_SPLIT_EN
      r_cross  <= 1'b0;
      r_word0  <= '0;
`endif
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bif.reqValid && r_live) begin
            r_waddr  <= {bif.reqAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_off    <= bif.reqAddr[OFF_W-1:0];
            r_mode   <= bif.reqMode;
            r_signed <= bif.reqSigned;
            r_err    <= 1'b0;
`ifdef MEM_SPLIT_EN
            r_cross  <= w_req_cross;
            r_state  <= S_RD0;
`else
            if (w_req_cross) begin
              r_data  <= '0;
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_state <= S_RD0;
            end
`endif
          end
        end
        S_RD0: if (bif.busReady) r_state <= S_WT0;
        S_WT0: begin
          if (bif.busRspValid) begin
`ifdef MEM_SPLIT_EN
            if (r_cross) begin
              r_word0 <= bif.busRdata;
              r_state <= S_RD1;
            end else begin
              r_data  <= w_ext;
              r_state <= S_RESP;
            end
`else
            r_data  <= w_ext;
            r_state <= S_RESP;
`endif
          end
        end
`ifdef MEM_SPLIT_EN
        S_RD1: if (bif.busReady) r_state <= S_WT1;
        S_WT1: begin
          if (bif.busRspValid) begin
            r_data  <= w_ext;
            r_state <= S_RESP;
          end
        end
`endif
        S_RESP:  if (bif.rspReady) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bif.reqReady = r_live && (r_state == S_IDLE);
  assign bif.rspValid = (r_state == S_RESP);
  assign bif.rspData  = r_data;
  assign bif.rspErr   = r_err;

`ifdef MEM_SPLIT_EN
  assign bif.busValid = (r_state == S_RD0) || (r_state == S_RD1);
  assign bif.busAddr  = (r_state == S_RD0) ? r_waddr :
                        (r_state == S_RD1) ? r_waddr + ADDR_W'(BYTES) : '0;
`else
  assign bif.busValid = (r_state == S_RD0);
  assign bif.busAddr  = (r_state == S_RD0) ? r_waddr : '0;
`endif
endmodule

// File: tb/tb_mem_load_align.sv
// Directed bench for mem_load_align with a zero-wait memory responder and stray-strobe injection.
module tb_mem_load_align;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  mem_load_align_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

  mem_load_align #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bif  (bif.slave)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          nreads = 0;
  int          acc_cyc = 0;
  int          base_reads = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] prev_addr = '0;
  logic        auto_en = 1'b1;
  logic        rsp_auto = 1'b0;
  logic        stray_vld = 1'b0;
  logic [31:0] rsp_dat = '0;
  logic [31:0] stray_dat = '0;

  assign bif.busRspValid = rsp_auto | stray_vld;
  assign bif.busRdata    = stray_vld ? stray_dat : rsp_dat;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_rd = 32'h0000_00A5;
      32'h0000_0100: mem_rd = 32'h8899_AABB;
      32'h0000_0104: mem_rd = 32'h1122_3344;
      default:       mem_rd = 32'hCAFE_F00D;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rsp_auto <= 1'b0;
    if (auto_en && bif.busValid && bif.busReady) begin
      rsp_auto  <= 1'b1;
      rsp_dat   <= mem_rd(bif.busAddr);
      nreads    <= nreads + 1;
      prev_addr <= last_addr;
      last_addr <= bif.busAddr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [1:0] m, input logic s);
    int n = 0;
    bif.reqValid  = 1'b1;
    bif.reqAddr   = a;
    bif.reqMode   = m;
    bif.reqSigned = s;
    while (!bif.reqReady && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      n_chk++;
      n_err++;
      $error("FAIL req_accept: observed=timeout expected=reqReady");
    end
    acc_cyc    = cyc;
    base_reads = nreads;
    @(posedge clk); #1;
    bif.reqValid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int n = 0;
    while (!bif.rspValid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_err++;
      $error("FAIL rsp_wait: observed=timeout expected=rspValid");
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic finish_rsp();
    bif.rspReady = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bif.reqValid  = 1'b0;
    bif.reqAddr   = '0;
    bif.reqMode   = MEM_B;
    bif.reqSigned = 1'b0;
    bif.busReady  = 1'b1;
    bif.rspReady  = 1'b1;

    #12;
    chk("rst_reqReady", 32'(bif.reqReady), 32'd0);
    chk("rst_busValid", 32'(bif.busValid), 32'd0);
    chk("rst_busAddr",  bif.busAddr, 32'd0);
    chk("rst_rspValid", 32'(bif.rspValid), 32'd0);
    chk("rst_rspData",  bif.rspData, 32'd0);
    chk("rst_rspErr",   32'(bif.rspErr), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_reqReady", 32'(bif.reqReady), 32'd1);

    do_req(32'h102, MEM_B, 1'b1);
    wait_rsp(lat);
    chk("b_s_data", bif.rspData, 32'hFFFF_FF99);
    chk("b_s_err",  32'(bif.rspErr), 32'd0);
    chk("b_s_lat",  32'(lat), 32'd3);
    chk("b_s_reads", 32'(nreads - base_reads), 32'd1);
    chk("b_s_addr", last_addr, 32'h100);
    finish_rsp();

    do_req(32'h102, MEM_B, 1'b0);
    wait_rsp(lat);
    chk("b_u_data", bif.rspData, 32'h0000_0099);
    finish_rsp();

    do_req(32'h101, MEM_H, 1'b1);
    wait_rsp(lat);
    chk("h_s_data",  bif.rspData, 32'hFFFF_99AA);
    chk("h_s_reads", 32'(nreads - base_reads), 32'd1);
    chk("h_s_addr",  last_addr, 32'h100);
    finish_rsp();

    do_req(32'h100, MEM_H, 1'b0);
    wait_rsp(lat);
    chk("h_u_data", bif.rspData, 32'h0000_AABB);
    finish_rsp();

    do_req(32'h100, MEM_W, 1'b1);
    wait_rsp(lat);
    chk("w_s_data", bif.rspData, 32'h8899_AABB);
    finish_rsp();

    do_req(32'h103, MEM_W, 1'b0);
    wait_rsp(lat);
`ifdef MEM_SPLIT_EN
    chk("x_w_data",  bif.rspData, 32'h2233_4488);
    chk("x_w_err",   32'(bif.rspErr), 32'd0);
    chk("x_w_lat",   32'(lat), 32'd5);
    chk("x_w_reads", 32'(nreads - base_reads), 32'd2);
    chk("x_w_addr0", prev_addr, 32'h100);
    chk("x_w_addr1", last_addr, 32'h104);
`else
    chk("x_w_data",  bif.rspData, 32'd0);
    chk("x_w_err",   32'(bif.rspErr), 32'd1);
    chk("x_w_lat",   32'(lat), 32'd1);
    chk("x_w_reads", 32'(nreads - base_reads), 32'd0);
`endif
    finish_rsp();

    do_req(32'h103, MEM_H, 1'b1);
    wait_rsp(lat);
`ifdef MEM_SPLIT_EN
    chk("x_h_data", bif.rspData, 32'h0000_4488);
    chk("x_h_err",  32'(bif.rspErr), 32'd0);
`else
    chk("x_h_data", bif.rspData, 32'd0);
    chk("x_h_err",  32'(bif.rspErr), 32'd1);
`endif
    finish_rsp();

    bif.rspReady = 1'b0;
    do_req(32'h104, MEM_W, 1'b0);
    wait_rsp(lat);
    chk("hold_lat",  32'(lat), 32'd3);
    chk("hold_data", bif.rspData, 32'h1122_3344);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_rspValid", 32'(bif.rspValid), 32'd1);
      chk("hold_rspData",  bif.rspData, 32'h1122_3344);
      chk("hold_reqReady", 32'(bif.reqReady), 32'd0);
    end
    finish_rsp();
    chk("hold_done_rspValid", 32'(bif.rspValid), 32'd0);
    chk("hold_done_reqReady", 32'(bif.reqReady), 32'd1);

    bif.busReady = 1'b0;
    do_req(32'h100, MEM_B, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_busValid", 32'(bif.busValid), 32'd1);
      chk("stall_busAddr",  bif.busAddr, 32'h100);
      @(posedge clk); #1;
    end
    bif.busReady = 1'b1;
    wait_rsp(lat);
    chk("stall_data", bif.rspData, 32'h0000_00BB);
    chk("stall_lat",  32'(lat), 32'd7);
    finish_rsp();

    stray_dat = 32'hDEAD_BEEF;
    stray_vld = 1'b1;
    @(posedge clk); #1;
    stray_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_idle_rspValid", 32'(bif.rspValid), 32'd0);
      @(posedge clk); #1;
    end

    auto_en = 1'b0;
    do_req(32'h100, MEM_W, 1'b0);
    @(posedge clk); #1;
    chk("wt0_busValid", 32'(bif.busValid), 32'd0);
    chk("wt0_rspValid", 32'(bif.rspValid), 32'd0);
    rstN = 1'b0;
    #1;
    chk("midrst_reqReady", 32'(bif.reqReady), 32'd0);
    chk("midrst_rspData",  bif.rspData, 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    auto_en   = 1'b1;
    stray_vld = 1'b1;
    @(posedge clk); #1;
    stray_vld = 1'b0;
    chk("midrst_stray_rspValid", 32'(bif.rspValid), 32'd0);
    chk("midrst_stray_busValid", 32'(bif.busValid), 32'd0);
    do_req(32'h0, MEM_B, 1'b1);
    wait_rsp(lat);
    chk("midrst_new_data", bif.rspData, 32'hFFFF_FFA5);
    chk("midrst_new_err",  32'(bif.rspErr), 32'd0);
    chk("midrst_new_lat",  32'(lat), 32'd3);
    finish_rsp();
    chk("midrst_after_rspValid", 32'(bif.rspValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
